// File: rtl/serial_frame_receiver.sv
// Oversampling UART-style receiver: majority-vote bit sampling, false-start
// rejection, and separate parity, framing and break reporting.
module serial_frame_receiver #(
    parameter int OVERSAMPLE = 4,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_x,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_parity_error,
    output logic                 o_framing_error,
    output logic                 o_break,
    output logic                 o_busy
);

    localparam int PW = $clog2(OVERSAMPLE);
    localparam int M  = OVERSAMPLE / 2;
    localparam logic [PW-1:0] PH_S0   = PW'(M - 1);
    localparam logic [PW-1:0] PH_S1   = PW'(M);
    localparam logic [PW-1:0] PH_DEC  = PW'(M + 1);
    localparam logic [PW-1:0] PH_LAST = PW'(OVERSAMPLE - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic          PAR_ODD   = (PARITY == 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t                 state;
    logic [PW-1:0]          phase;
    logic [3:0]             bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   rx_meta;
    logic                   rx_sync;
    logic                   rx_prev;
    logic                   samp0;
    logic                   samp1;
    logic                   par_bit;
    logic                   stop_ok;
    logic                   any_one;

    logic                   maj;
    logic                   decide;
    logic                   wrap;
    logic                   fell;
    logic                   par_exp;

    assign maj     = (samp0 & samp1) | (samp0 & rx_sync) | (samp1 & rx_sync);
    assign decide  = (phase == PH_DEC);
    assign wrap    = (phase == PH_LAST);
    assign fell    = rx_prev & ~rx_sync;
    assign par_exp = (^shreg) ^ PAR_ODD;

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            state           <= IDLE;
            phase           <= '0;
            bit_cnt         <= '0;
            shreg           <= '0;
            samp0           <= 1'b1;
            samp1           <= 1'b1;
            par_bit         <= 1'b0;
            stop_ok         <= 1'b1;
            any_one         <= 1'b0;
            o_data          <= '0;
            o_valid         <= 1'b0;
            o_parity_error  <= 1'b0;
            o_framing_error <= 1'b0;
            o_break         <= 1'b0;
            o_busy          <= 1'b0;
        end else begin
            o_valid         <= 1'b0;
            o_parity_error  <= 1'b0;
            o_framing_error <= 1'b0;
            o_break         <= 1'b0;
            phase           <= wrap ? '0 : phase + 1'b1;
            if (phase == PH_S0) samp0 <= rx_sync;
            if (phase == PH_S1) samp1 <= rx_sync;

            case (state)
                IDLE: begin
                    if (fell) begin
                        state   <= START;
                        phase   <= '0;
                        bit_cnt <= '0;
                        stop_ok <= 1'b1;
                        any_one <= 1'b0;
                        o_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (decide && maj) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end else if (wrap) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (decide) begin
                        shreg   <= {maj, shreg[DATA_BITS-1:1]};
                        any_one <= any_one | maj;
                    end
                    if (wrap) begin
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            state   <= (PARITY != 0) ? PAR : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                PAR: begin
                    if (decide) begin
                        par_bit <= maj;
                        any_one <= any_one | maj;
                    end
                    if (wrap) state <= STOP;
                end
                STOP: begin
                    if (wrap && bit_cnt != STOP_LAST) bit_cnt <= bit_cnt + 1'b1;
                    if (decide && bit_cnt != STOP_LAST) begin
                        stop_ok <= stop_ok & maj;
                        any_one <= any_one | maj;
                    end else if (decide) begin
                        if (!(any_one | maj)) begin
                            o_break <= 1'b1;
                            o_data  <= '0;
                            state   <= WAIT_HIGH;
                        end else begin
                            o_data <= shreg;
                            if (stop_ok & maj) begin
                                o_valid        <= 1'b1;
                                o_parity_error <= (PARITY != 0) && (par_bit != par_exp);
                            end else begin
                                o_framing_error <= 1'b1;
                            end
                            // A start edge landing on this cycle would be lost by the
                            // IDLE edge detector, so it re-arms the frame directly.
                            if (fell) begin
                                state   <= START;
                                phase   <= '0;
                                bit_cnt <= '0;
                                stop_ok <= 1'b1;
                                any_one <= 1'b0;
                            end else begin
                                state  <= IDLE;
                                o_busy <= 1'b0;
                            end
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (rx_sync) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench: default 8N1 x4 receiver plus a 7E2 instance, frames driven
// one bit cell at a time with hand-computed expected results.
module tb_serial_frame_receiver;

    logic       clk   = 1'b0;
    logic       rst_x = 1'b0;
    logic       rx_a  = 1'b1;
    logic       rx_b  = 1'b1;

    logic [7:0] data_a;
    logic       valid_a, perr_a, ferr_a, brk_a, busy_a;
    logic [6:0] data_b;
    logic       valid_b, perr_b, ferr_b, brk_b, busy_b;

    int         vectors     = 0;
    int         miscompares = 0;
    int         cyc         = 0;
    int         start_cyc   = 0;
    int         pulse_cyc   = 0;
    int         lat;
    int         vcnt[2]  = '{0, 0};
    int         pcnt[2]  = '{0, 0};
    int         stray[2] = '{0, 0};
    int         fcnt[2]  = '{0, 0};
    int         bcnt[2]  = '{0, 0};
    logic [7:0] log_a[$];
    logic [6:0] log_b[$];

    always #4 clk = ~clk;

    always @(posedge clk) cyc++;

    serial_frame_receiver u_def (
        .clk             (clk),
        .rst_x           (rst_x),
        .i_rx            (rx_a),
        .o_data          (data_a),
        .o_valid         (valid_a),
        .o_parity_error  (perr_a),
        .o_framing_error (ferr_a),
        .o_break         (brk_a),
        .o_busy          (busy_a)
    );

    serial_frame_receiver #(
        .OVERSAMPLE (4),
        .DATA_BITS  (7),
        .PARITY     (2),
        .STOP_BITS  (2)
    ) u_7e2 (
        .clk             (clk),
        .rst_x           (rst_x),
        .i_rx            (rx_b),
        .o_data          (data_b),
        .o_valid         (valid_b),
        .o_parity_error  (perr_b),
        .o_framing_error (ferr_b),
        .o_break         (brk_b),
        .o_busy          (busy_b)
    );

    // Pulse monitor, sampled mid-cycle away from the active edge.
    always @(negedge clk) begin
        if (valid_a) begin vcnt[0]++; log_a.push_back(data_a); end
        if (perr_a && valid_a) pcnt[0]++;
        if (perr_a && !valid_a) stray[0]++;
        if (ferr_a) fcnt[0]++;
        if (brk_a) bcnt[0]++;
        if (valid_a || ferr_a || brk_a) pulse_cyc = cyc;
        if (valid_b) begin vcnt[1]++; log_b.push_back(data_b); end
        if (perr_b && valid_b) pcnt[1]++;
        if (perr_b && !valid_b) stray[1]++;
        if (ferr_b) fcnt[1]++;
        if (brk_b) bcnt[1]++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives bits LSB first, one cell each; jitter gives 33/31/32 unit cells.
    task automatic applyStimulus(input bit which, input logic [31:0] bits,
                                 input int nbits, input bit jitter);
        int len;
        @(negedge clk);
        start_cyc = cyc;
        for (int i = 0; i < nbits; i++) begin
            if (which) rx_b = bits[i];
            else       rx_a = bits[i];
            len = 32;
            if (jitter) len = (i % 3 == 0) ? 33 : ((i % 3 == 1) ? 31 : 32);
            #(len);
        end
    endtask

    task automatic clearCounts();
        for (int i = 0; i < 2; i++) begin
            vcnt[i] = 0; pcnt[i] = 0; stray[i] = 0; fcnt[i] = 0; bcnt[i] = 0;
        end
        log_a.delete();
        log_b.delete();
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        $display("[TB] serial_frame_receiver directed test start");
        settle(3);
        checkOutput("reset_a", {data_a, valid_a, perr_a, ferr_a, brk_a, busy_a}, 32'h0);
        checkOutput("reset_b", {data_b, valid_b, perr_b, ferr_b, brk_b, busy_b}, 32'h0);
        rst_x = 1'b1;
        settle(4);

        // Back-to-back 0x4D, 0xAA with no idle gap
        clearCounts();
        applyStimulus(1'b0, {1'b1, 8'hAA, 1'b0, 1'b1, 8'h4D, 1'b0}, 20, 1'b0);
        settle(12);
        checkOutput("b2b_valid_count", vcnt[0], 2);
        checkOutput("b2b_first", (log_a.size() > 0) ? log_a[0] : 8'hxx, 8'h4D);
        checkOutput("b2b_second", (log_a.size() > 1) ? log_a[1] : 8'hxx, 8'hAA);
        checkOutput("b2b_errors", fcnt[0] + bcnt[0] + pcnt[0] + stray[0], 0);
        checkOutput("b2b_busy", busy_a, 1'b0);

        // 0xFF with stop bit low
        clearCounts();
        applyStimulus(1'b0, {1'b0, 8'hFF, 1'b0}, 10, 1'b0);
        rx_a = 1'b1;
        settle(12);
        checkOutput("ferr_count", fcnt[0], 1);
        checkOutput("ferr_no_valid", vcnt[0], 0);
        checkOutput("ferr_data", data_a, 8'hFF);
        checkOutput("ferr_busy", busy_a, 1'b0);
        lat = pulse_cyc - start_cyc - 1;
        checkOutput("latency_42pm1", (lat >= 41 && lat <= 43), 1'b1);

        // 0x55 with jittered cell widths
        clearCounts();
        applyStimulus(1'b0, {1'b1, 8'h55, 1'b0}, 10, 1'b1);
        settle(12);
        checkOutput("jitter_valid", vcnt[0], 1);
        checkOutput("jitter_data", data_a, 8'h55);
        checkOutput("jitter_errors", fcnt[0] + bcnt[0], 0);

        // One-clock low glitch on an idle line
        clearCounts();
        @(negedge clk);
        rx_a = 1'b0;
        @(negedge clk);
        rx_a = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("glitch_busy_high", busy_a, 1'b1);
        settle(4);
        checkOutput("glitch_busy_low", busy_a, 1'b0);
        settle(8);
        checkOutput("glitch_no_pulse", vcnt[0] + fcnt[0] + bcnt[0] + stray[0], 0);

        // 7E2: good parity, bad parity, second stop bit low
        clearCounts();
        applyStimulus(1'b1, {2'b11, 1'b0, 7'h41, 1'b0}, 11, 1'b0);
        settle(12);
        checkOutput("par_ok_valid", vcnt[1], 1);
        checkOutput("par_ok_data", data_b, 7'h41);
        checkOutput("par_ok_perr", pcnt[1], 0);
        applyStimulus(1'b1, {2'b11, 1'b1, 7'h41, 1'b0}, 11, 1'b0);
        settle(12);
        checkOutput("par_bad_valid", vcnt[1], 2);
        checkOutput("par_bad_perr", pcnt[1], 1);
        applyStimulus(1'b1, {1'b0, 1'b1, 1'b0, 7'h41, 1'b0}, 11, 1'b0);
        rx_b = 1'b1;
        settle(12);
        checkOutput("stop2_ferr", fcnt[1], 1);
        checkOutput("stop2_no_valid", vcnt[1], 2);
        checkOutput("par_stray", stray[1] + bcnt[1], 0);

        // Line held low for 30 bit times
        clearCounts();
        @(negedge clk);
        rx_a = 1'b0;
        #(30 * 32);
        #1;
        checkOutput("break_count", bcnt[0], 1);
        checkOutput("break_busy_held", busy_a, 1'b1);
        checkOutput("break_data", data_a, 8'h00);
        checkOutput("break_no_other", vcnt[0] + fcnt[0], 0);
        rx_a = 1'b1;
        settle(6);
        checkOutput("break_busy_release", busy_a, 1'b0);
        applyStimulus(1'b0, {1'b1, 8'h12, 1'b0}, 10, 1'b0);
        settle(12);
        checkOutput("after_break_valid", vcnt[0], 1);
        checkOutput("after_break_data", data_a, 8'h12);
        checkOutput("after_break_single", bcnt[0], 1);

        // Reset asserted half-way through data bit 4
        clearCounts();
        applyStimulus(1'b0, {1'b1, 8'hA5, 1'b0}, 5, 1'b0);
        rx_a = 1'b0;
        #16;
        checkOutput("midreset_busy_before", busy_a, 1'b1);
        rst_x = 1'b0;
        #1;
        checkOutput("midreset_outputs", {data_a, valid_a, perr_a, ferr_a, brk_a, busy_a}, 32'h0);
        rx_a = 1'b1;
        #10;
        rst_x = 1'b1;
        settle(4);
        applyStimulus(1'b0, {1'b1, 8'h3C, 1'b0}, 10, 1'b0);
        settle(12);
        checkOutput("midreset_valid", vcnt[0], 1);
        checkOutput("midreset_data", data_a, 8'h3C);
        checkOutput("midreset_no_err", fcnt[0] + bcnt[0], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
